// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between NUM_REQ requesters.
// Round-robin arbitration in IDLE latches the winner's command. The block then
// runs the SETUP and ACCESS phases and returns rdata/error with a one-cycle done.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase that has waited
// TIMEOUT_CYCLES cycles; the abort reports trans_err_o=1 and rdata_o=0.
//
// state  | meaning
// IDLE   | no transfer; arbitrate among pending requesters
// SETUP  | APB setup phase (pselx=1, penable=0)
// ACCESS | APB access phase (pselx=1, penable=1), waiting for pready
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic [NUM_REQ-1:0]              req_trans_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ-1:0]              req_wr_rd_i,
  output logic [NUM_REQ-1:0]              req_gnt_o,
  output logic [NUM_REQ-1:0]              req_done_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            trans_err_o,
  output logic                            pselx,
  output logic                            penable,
  output logic                            pwrite,
  output logic [ADDR_WIDTH-1:0]           paddr,
  output logic [DATA_WIDTH-1:0]           pwdata,
  input  logic [DATA_WIDTH-1:0]           prdata,
  input  logic                            pready,
  input  logic                            pslverr,
  output logic                            busy_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject parameter values the arbiter was not built for.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_master_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   psel_q, psel_d;
  logic                   pen_q, pen_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;

  logic [NUM_REQ-1:0]     eligible;
  logic                   found;
  logic [PW-1:0]          win;
  logic [PW-1:0]          cand;
  logic                   timeout;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  assign timeout = (to_cnt_q == TW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search from ptr+1; the requester completing this cycle is masked.
  always_comb begin
    eligible = req_trans_i & ~done_q;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
`ifdef APB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        psel_d = 1'b0;
        pen_d  = 1'b0;
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          paddr_d    = req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d   = req_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
          pwrite_d   = req_wr_rd_i[win];
          ptr_d      = win;
          psel_d     = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        psel_d  = 1'b1;
        pen_d   = 1'b1;
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready || timeout) begin
          if (pready) begin
            err_d   = pslverr;
            rdata_d = pwrite_q ? '0 : prdata;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
          done_d  = gnt_q;
          gnt_d   = '0;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          state_d = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        gnt_d   = '0;
        psel_d  = 1'b0;
        pen_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      ptr_q    <= PW'(NUM_REQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
`ifdef APB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign req_gnt_o   = gnt_q;
  assign req_done_o  = done_q;
  assign rdata_o     = rdata_q;
  assign trans_err_o = err_q;
  assign pselx       = psel_q;
  assign penable     = pen_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (NUM_REQ=4, 32-bit bus, TIMEOUT_CYCLES=4).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_apb_master_arbiter;

  logic         pclk;
  logic         preset;
  logic [3:0]   req_trans;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_wr_rd;
  logic [3:0]   req_gnt;
  logic [3:0]   req_done;
  logic [31:0]  rdata;
  logic         trans_err;
  logic         pselx, penable, pwrite;
  logic [31:0]  paddr, pwdata, prdata;
  logic         pready, pslverr;
  logic         busy;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_trans_i(req_trans), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wr_rd_i(req_wr_rd), .req_gnt_o(req_gnt), .req_done_o(req_done),
    .rdata_o(rdata), .trans_err_o(trans_err),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy_o(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_trans[i]          = 1'b1;
    req_wr_rd[i]          = wr;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; req_trans = '0; req_addr = '0; req_wdata = '0; req_wr_rd = '0;
    prdata = '0; pready = 1'b1; pslverr = 1'b0;
    tick; tick;
    chk("rst_gnt", req_gnt, 4'h0);
    chk("rst_done", req_done, 4'h0);
    chk("rst_psel", pselx, 1'b0);
    chk("rst_pen", penable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", trans_err, 1'b0);
    preset = 1'b0;

    // Single write from requester 0, no wait states.
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    tick;
    chk("w_gnt", req_gnt, 4'b0001);
    chk("w_setup_psel", pselx, 1'b1);
    chk("w_setup_pen", penable, 1'b0);
    chk("w_paddr", paddr, 32'h10);
    chk("w_pwrite", pwrite, 1'b1);
    chk("w_pwdata", pwdata, 32'hA5A5_0001);
    chk("w_busy", busy, 1'b1);
    tick;
    chk("w_acc_psel", pselx, 1'b1);
    chk("w_acc_pen", penable, 1'b1);
    tick;
    chk("w_done", req_done, 4'b0001);
    chk("w_gnt_clr", req_gnt, 4'h0);
    chk("w_psel_clr", pselx, 1'b0);
    chk("w_err", trans_err, 1'b0);
    chk("w_rdata", rdata, 32'h0);
    req_trans[0] = 1'b0;
    tick;
    chk("w_done_1cyc", req_done, 4'h0);
    chk("w_idle_gnt", req_gnt, 4'h0);
    chk("w_idle_busy", busy, 1'b0);

    // Read from requester 2 with two wait states; later input changes ignored.
    prdata = 32'hDEAD_BEEF; pready = 1'b0;
    set_req(2, 1'b0, 32'h24, 32'h0);
    tick;
    chk("r_gnt", req_gnt, 4'b0100);
    chk("r_paddr", paddr, 32'h24);
    chk("r_pwrite", pwrite, 1'b0);
    req_addr[64 +: 32] = 32'hFFF;
    tick;
    chk("r_pen1", penable, 1'b1);
    pslverr = 1'b1;
    tick;
    chk("r_pen2", penable, 1'b1);
    chk("r_paddr_hold", paddr, 32'h24);
    chk("r_nodone2", req_done, 4'h0);
    tick;
    chk("r_pen3", penable, 1'b1);
    chk("r_nodone3", req_done, 4'h0);
    pready = 1'b1; pslverr = 1'b0;
    tick;
    chk("r_done", req_done, 4'b0100);
    chk("r_rdata", rdata, 32'hDEAD_BEEF);
    chk("r_err", trans_err, 1'b0);
    chk("r_pen_clr", penable, 1'b0);
    req_trans[2] = 1'b0;
    tick;

    // Slave error on a write from requester 1, then a clean read from 3.
    pslverr = 1'b1;
    set_req(1, 1'b1, 32'h30, 32'h1234);
    tick;
    chk("e_gnt", req_gnt, 4'b0010);
    tick; tick;
    chk("e_done", req_done, 4'b0010);
    chk("e_err", trans_err, 1'b1);
    chk("e_rdata", rdata, 32'h0);
    req_trans[1] = 1'b0; pslverr = 1'b0;
    tick;
    chk("e_err_hold", trans_err, 1'b1);
    prdata = 32'h55AA;
    set_req(3, 1'b0, 32'h40, 32'h0);
    tick;
    chk("e2_gnt", req_gnt, 4'b1000);
    tick; tick;
    chk("e2_done", req_done, 4'b1000);
    chk("e2_err", trans_err, 1'b0);
    chk("e2_rdata", rdata, 32'h55AA);
    req_trans[3] = 1'b0;
    tick;

    // Round robin: all four requesting out of reset, each dropped at its done.
    preset = 1'b1; prdata = 32'h0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
    tick;
    preset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_gnt", req_gnt, 64'(4'b0001 << i));
      chk("rr_paddr", paddr, 64'(32'h100 + 32'(i * 4)));
      tick; tick;
      chk("rr_done", req_done, 64'(4'b0001 << i));
      req_trans[i] = 1'b0;
    end
    set_req(0, 1'b0, 32'h200, 32'h0);
    set_req(1, 1'b0, 32'h204, 32'h0);
    tick;
    chk("rr2_gnt0", req_gnt, 4'b0001);
    tick; tick;
    chk("rr2_done0", req_done, 4'b0001);
    req_trans[0] = 1'b0;
    tick;
    chk("rr2_gnt1", req_gnt, 4'b0010);
    tick; tick;
    chk("rr2_done1", req_done, 4'b0010);
    req_trans[1] = 1'b0;
    tick;

    // Single requester held high: masked in its done cycle, re-granted after.
    set_req(2, 1'b0, 32'h50, 32'h0);
    tick;
    chk("h_gnt", req_gnt, 4'b0100);
    tick; tick;
    chk("h_done", req_done, 4'b0100);
    tick;
    chk("h_masked", req_gnt, 4'h0);
    chk("h_masked_done", req_done, 4'h0);
    tick;
    chk("h_regnt", req_gnt, 4'b0100);
    req_trans[2] = 1'b0;
    tick; tick;
    chk("h_done2", req_done, 4'b0100);
    tick;

    // Reset in the middle of a waited ACCESS phase.
    pready = 1'b0;
    set_req(1, 1'b1, 32'h60, 32'h77);
    tick;
    chk("x_gnt", req_gnt, 4'b0010);
    tick; tick;
    chk("x_pen", penable, 1'b1);
    preset = 1'b1; req_trans[1] = 1'b0;
    tick;
    chk("x_psel", pselx, 1'b0);
    chk("x_pen_clr", penable, 1'b0);
    chk("x_gnt_clr", req_gnt, 4'h0);
    chk("x_nodone", req_done, 4'h0);
    chk("x_busy", busy, 1'b0);
    preset = 1'b0; pready = 1'b1;
    set_req(0, 1'b0, 32'h70, 32'h0);
    set_req(3, 1'b0, 32'h74, 32'h0);
    tick;
    chk("x_first0", req_gnt, 4'b0001);
    tick; tick;
    chk("x_done0", req_done, 4'b0001);
    req_trans[0] = 1'b0;
    tick;
    chk("x_then3", req_gnt, 4'b1000);
    tick; tick;
    chk("x_done3", req_done, 4'b1000);
    req_trans[3] = 1'b0;
    tick;

`ifdef APB_TIMEOUT_EN
    // ACCESS abort after four wait cycles.
    pready = 1'b0; prdata = 32'h1;
    set_req(1, 1'b0, 32'h80, 32'h0);
    tick;
    chk("t_gnt", req_gnt, 4'b0010);
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t_wait", req_done, 4'h0);
    end
    tick;
    chk("t_done", req_done, 4'b0010);
    chk("t_err", trans_err, 1'b1);
    chk("t_rdata", rdata, 32'h0);
    req_trans[1] = 1'b0; pready = 1'b1;
    tick;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
